fredkin_descrambler: RTL and testbench



---
 rtl/fredkin_pkg.sv | 30 +++
 rtl/fredkin_swap_stage.sv | 32 +++
 rtl/fredkin_descrambler.sv | 106 ++++++++++
 tb/tb_fredkin_descrambler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fredkin_pkg.sv
// rtl/fredkin_pkg.sv - shared FSM encoding and Fredkin pairing helpers
package fredkin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lower bit index of gate k: even stages pair (2k,2k+1), odd stages (2k+1,2k+2)
    function automatic int pair_lo(input logic odd, input int k);
        return odd ? (2 * k + 1) : (2 * k);
    endfunction

    // Upper bit index of gate k; the last odd-stage gate wraps around to bit 0
    function automatic int pair_hi(input logic odd, input int k, input int width);
        if (!odd)
            return 2 * k + 1;
        else if (k == width / 2 - 1)
            return 0;
        else
            return 2 * k + 2;
    endfunction

    // Stage counter width, never narrower than one bit
    function automatic int cnt_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/fredkin_swap_stage.sv
// rtl/fredkin_swap_stage.sv - one combinational layer of disjoint Fredkin gates
module fredkin_swap_stage
    import fredkin_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH/2-1:0] ctl,
    input  logic               odd,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] q_even;
    logic [WIDTH-1:0] q_odd;

    // Both pairings are built; the stage parity picks one. Each layer covers
    // every bit exactly once, so each output bit has a single driver.
    for (genvar k = 0; k < WIDTH / 2; k++) begin : g_gate
        localparam int EL = pair_lo(1'b0, k);
        localparam int EH = pair_hi(1'b0, k, WIDTH);
        localparam int OL = pair_lo(1'b1, k);
        localparam int OH = pair_hi(1'b1, k, WIDTH);

        assign q_even[EL] = ctl[k] ? d[EH] : d[EL];
        assign q_even[EH] = ctl[k] ? d[EL] : d[EH];
        assign q_odd[OL]  = ctl[k] ? d[OH] : d[OL];
        assign q_odd[OH]  = ctl[k] ? d[OL] : d[OH];
    end

    assign q = odd ? q_odd : q_even;

endmodule

// File: rtl/fredkin_descrambler.sv
// rtl/fredkin_descrambler.sv - iterative inverse Fredkin network, one stage per clock
module fredkin_descrambler
    import fredkin_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [STAGES*(WIDTH/2)-1:0]   in_key,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          busy
);

    localparam int HALF = WIDTH / 2;
    localparam int KW   = STAGES * HALF;
    localparam int CW   = cnt_width(STAGES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STAGES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [KW-1:0]    key_q, key_d;
    logic [HALF-1:0]  ctl;
    logic [WIDTH-1:0] stage_out;

    // Pick the key slice for the stage currently being undone
    always_comb begin
        ctl = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (cnt_q == CW'(s))
                ctl = key_q[s*HALF +: HALF];
        end
    end

    fredkin_swap_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .d   (data_q),
        .ctl (ctl),
        .odd (cnt_q[0]),
        .q   (stage_out)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
        end
    end

    // Next state: latch in IDLE, count stages down in RUN, hold in DONE until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    key_d   = in_key;
                    cnt_d   = CNT_LAST;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = stage_out;
                if (cnt_q == '0)
                    state_d = ST_DONE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode purely from registered state, so inputs never reach outputs combinationally
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_data  = (state_q == ST_DONE) ? data_q : '0;
    end

endmodule

// File: tb/tb_fredkin_descrambler.sv
// tb/tb_fredkin_descrambler.sv - randomized round-trip bench for fredkin_descrambler
module tb_fredkin_descrambler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic [31:0] in_key;
    logic        out_ready;
    int          sel;

    logic        ir0, ov0, bz0;
    logic [7:0]  od0;
    logic        ir1, ov1, bz1;
    logic [7:0]  od1;
    logic        ir2, ov2, bz2;
    logic [15:0] od2;

    logic        cur_ir, cur_ov, cur_busy;
    logic [15:0] cur_od;
    int          cur_w, cur_s;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fredkin_descrambler #(.WIDTH(8), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 0), .in_ready(ir0),
        .in_data(in_data[7:0]), .in_key(in_key[15:0]),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(bz0)
    );

    fredkin_descrambler #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 1), .in_ready(ir1),
        .in_data(in_data[7:0]), .in_key(in_key[3:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1)
    );

    fredkin_descrambler #(.WIDTH(16), .STAGES(4)) u_dut_w16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == 2), .in_ready(ir2),
        .in_data(in_data), .in_key(in_key),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(bz2)
    );

    always_comb begin
        cur_ir = ir0; cur_ov = ov0; cur_busy = bz0; cur_od = {8'h00, od0}; cur_w = 8; cur_s = 4;
        if (sel == 1) begin
            cur_ir = ir1; cur_ov = ov1; cur_busy = bz1; cur_od = {8'h00, od1}; cur_w = 8; cur_s = 1;
        end else if (sel == 2) begin
            cur_ir = ir2; cur_ov = ov2; cur_busy = bz2; cur_od = od2; cur_w = 16; cur_s = 4;
        end
    end

    // Reference encoder: applies the network forwards from the pairing rules
    function automatic logic [15:0] ref_stage(input logic [15:0] v, input logic [31:0] key,
                                              input int s, input int w);
        logic [15:0] r;
        int a, b;
        r = v;
        for (int k = 0; k < w / 2; k++) begin
            if (s % 2 == 0) begin a = 2 * k;     b = 2 * k + 1; end
            else            begin a = 2 * k + 1; b = (2 * k + 2) % w; end
            if (key[s * (w / 2) + k]) begin
                r[a] = v[b];
                r[b] = v[a];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_encode(input logic [15:0] p, input logic [31:0] key,
                                               input int w, input int stages);
        logic [15:0] v;
        v = p;
        for (int s = 0; s < stages; s++) v = ref_stage(v, key, s, w);
        return v;
    endfunction

    function automatic logic [15:0] wmask(input int w);
        return (w == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [31:0] kmask(input int w, input int stages);
        int kw;
        kw = stages * (w / 2);
        return (kw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << kw) - 32'd1);
    endfunction

    // Push one word into the selected instance, scramble inputs while in flight,
    // and collect the result; handshakes the output only if out_ready is high
    task automatic xfer(input logic [15:0] d, input logic [31:0] k,
                        output logic [15:0] got, output int lat, output bit ok);
        int n;
        ok = 1'b1; n = 0; lat = 0; got = '0;
        while (!cur_ir && n < 50) begin @(posedge clk); #1; n++; end
        if (!cur_ir) begin ok = 1'b0; return; end
        in_data = d; in_key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!cur_ov && lat < 50) begin
            in_data = 16'($urandom); in_key = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_ov) begin ok = 1'b0; return; end
        got = cur_od;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic check_word(input string name, input logic [15:0] d, input logic [31:0] k,
                              input logic [15:0] exp, input int exp_lat);
        logic [15:0] got;
        int lat;
        bit ok;
        xfer(d, k, got, lat, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: handshake timeout (in_ready=%0b out_valid=%0b), required completion", name, cur_ir, cur_ov);
        end else begin
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s: out_data=%h required %h (in=%h key=%h)", name, got, exp, d, k);
            end
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL %s latency: %0d cycles required %0d", name, lat, exp_lat);
            end
        end
    endtask

    task automatic test_reset();
        sel = 0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        vectors++; if (cur_ir !== 1'b1)   begin miscompares++; $display("FAIL reset in_ready: %b required 1", cur_ir); end
        vectors++; if (cur_ov !== 1'b0)   begin miscompares++; $display("FAIL reset out_valid: %b required 0", cur_ov); end
        vectors++; if (cur_od !== 16'h0)  begin miscompares++; $display("FAIL reset out_data: %h required 0", cur_od); end
        vectors++; if (cur_busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: %b required 0", cur_busy); end
    endtask

    task automatic test_directed();
        sel = 0;
        check_word("identity", 16'h00A5, 32'h0000, 16'h00A5, 4);
        check_word("single_stage", 16'h00A5, 32'h000F, 16'h005A, 4);
        check_word("odd_wrap", 16'h0001, 32'h0080, 16'h0080, 4);
    endtask

    task automatic test_round_trip(input int inst, input int count);
        logic [15:0] p, enc;
        logic [31:0] k;
        sel = inst;
        #1;
        for (int i = 0; i < count; i++) begin
            p   = 16'($urandom) & wmask(cur_w);
            k   = $urandom & kmask(cur_w, cur_s);
            enc = ref_encode(p, k, cur_w, cur_s);
            check_word($sformatf("round_trip[%0d]", inst), enc, k, p, cur_s);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p, enc, got, hold;
        logic [31:0] k;
        int lat;
        bit ok;
        sel = 0;
        p = 16'($urandom) & 16'h00FF; k = $urandom & 32'hFFFF;
        enc = ref_encode(p, k, 8, 4);
        out_ready = 1'b0;
        xfer(enc, k, got, lat, ok);
        hold = got;
        vectors++;
        if (!ok || got !== p) begin
            miscompares++;
            $display("FAIL backpressure data: ok=%0b out_data=%h required %h", ok, got, p);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_data = 16'($urandom); in_key = $urandom;
            @(posedge clk); #1;
            vectors++; if (cur_ov !== 1'b1)  begin miscompares++; $display("FAIL bp out_valid[%0d]: %b required 1", i, cur_ov); end
            vectors++; if (cur_od !== hold)  begin miscompares++; $display("FAIL bp out_data[%0d]: %h required %h", i, cur_od, hold); end
            vectors++; if (cur_ir !== 1'b0)  begin miscompares++; $display("FAIL bp in_ready[%0d]: %b required 0", i, cur_ir); end
            vectors++; if (cur_busy !== 1'b1) begin miscompares++; $display("FAIL bp busy[%0d]: %b required 1", i, cur_busy); end
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (cur_ov !== 1'b0)   begin miscompares++; $display("FAIL bp release out_valid: %b required 0", cur_ov); end
        vectors++; if (cur_ir !== 1'b1)   begin miscompares++; $display("FAIL bp release in_ready: %b required 1", cur_ir); end
        vectors++; if (cur_busy !== 1'b0) begin miscompares++; $display("FAIL bp release busy (accepted during handshake): %b required 0", cur_busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p, enc;
        logic [31:0] k;
        sel = 0;
        in_data = 16'h00C3; in_key = 32'hBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (cur_ov !== 1'b0)   begin miscompares++; $display("FAIL midrst out_valid: %b required 0", cur_ov); end
        vectors++; if (cur_ir !== 1'b1)   begin miscompares++; $display("FAIL midrst in_ready: %b required 1", cur_ir); end
        vectors++; if (cur_busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy: %b required 0", cur_busy); end
        p = 16'h003C; k = 32'h5A96;
        enc = ref_encode(p, k, 8, 4);
        check_word("after_reset", enc, k, p, 4);
    endtask

    initial begin
        rst = 1'b1; sel = 0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_round_trip(0, 1000);
        test_backpressure();
        test_reset_mid_run();
        test_round_trip(1, 300);
        test_round_trip(2, 300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
